uart_rx_engine: RTL
===================

UART_RX_ENGINE -- requirements
Module: uart_rx_engine

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- EIGHT  in  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  in  1  1 = parity bit present.
- OHEL  in  1  parity sense: 1 = odd, 0 = even.
- k  in  19  bit time in clk cycles.
- RX  in  1  serial line, idle high.
- READ_CLR  in  1  one-cycle read strobe.
- RX_DATA  out  8  received character.
- RXRDY  out  1  character available.
- PERR  out  1  parity error.
- FERR  out  1  framing error.
- OVF  out  1  overrun.
REQ-002 EIGHT, PEN, OHEL and k SHALL be sampled only on the IDLE-to-START transition and held for the whole frame.

Function
REQ-003 Let the effective bit time be B = max(k, 2) and the half-bit time H = B >> 1.
REQ-004 The state machine SHALL have the states IDLE, START, SHIFT and STOP.
REQ-005 IDLE: a sampled RX of 0 SHALL move the block to START and clear the bit timer.
REQ-006 START: after H cycles, the block SHALL sample RX.
- RX = 1: false start; return to IDLE with no flag changes.
- RX = 0: go to SHIFT.
REQ-007 SHIFT: the block SHALL sample RX every B cycles.
- Bits sampled: 7 or 8 data bits (LSB first), then one parity bit if PEN = 1.
- After the last of these bits, go to STOP.
REQ-008 STOP: after B cycles, the block SHALL sample the stop bit and return to IDLE on the following cycle.
REQ-009 For a frame starting at detect cycle 0, sample n of the frame SHALL occur at cycle H + n*B; the start bit is n = 0.
REQ-010 The outputs SHALL update on the cycle after the stop sample:
- RX_DATA loads the character; with EIGHT = 0, RX_DATA[7] = 0.
- RXRDY = 1.
- FERR = (stop sample == 0).
- PERR = PEN & (received parity != computed parity).
- Computed parity is the XOR of the data bits, inverted when OHEL = 1; only the 7 data bits count when EIGHT = 0.
REQ-011 A framing error SHALL still load the data and set RXRDY.
REQ-012 A frame completing while RXRDY = 1 SHALL set OVF = 1 and overwrite RX_DATA, PERR and FERR.
REQ-013 READ_CLR SHALL clear RXRDY, PERR, FERR and OVF on the next edge; RX_DATA is held.
REQ-014 If a frame completes in the same cycle as READ_CLR, the completion SHALL win: RXRDY = 1, the new flags load, and OVF = 0.
REQ-015 A 0 on RX sampled in the cycle immediately after STOP SHALL start a new frame, so back-to-back frames are received with no lost cycle.
REQ-016 Any change to k mid-frame SHALL have no effect until the next start detection.

Reset
REQ-017 rst = 1 SHALL immediately force:
- state IDLE;
- timers and bit counter to 0;
- RX_DATA = 0x00;
- RXRDY = PERR = FERR = OVF = 0.
REQ-018 Reset asserted mid-frame SHALL discard the partial character.
REQ-019 After reset release, the block SHALL wait for a new falling edge; it SHALL NOT resume the discarded frame.

Configuration
REQ-020 With UART_RX_SYNC2_EN defined:
- RX passes through a two-flop synchronizer, reset to 1.
- All timings in REQ-009 and REQ-010 shift later by 2 cycles.
REQ-021 Without UART_RX_SYNC2_EN, RX SHALL be registered through a single flop, reset to 1, and the timings SHALL be exactly as stated.

Verification
REQ-022 k=10, 8N1, byte 0xA5 -> RXRDY rises at cycle 96 after the falling edge, RX_DATA=0xA5, PERR=FERR=OVF=0.
REQ-023 k=10, 7E1 (EIGHT=0, PEN=1, OHEL=0), char 0x41 with wrong parity bit 1 -> RX_DATA=0x41, PERR=1.
REQ-024 k=10, 8N1, 0x3C with stop bit 0 -> RX_DATA=0x3C, FERR=1, RXRDY=1.
REQ-025 k=10, two back-to-back frames 0x11 then 0x22 with no READ_CLR -> RX_DATA=0x22, OVF=1; then READ_CLR -> all flags 0, RX_DATA=0x22.
REQ-026 k=10, RX low for 3 cycles then high -> no RXRDY; a following 0x55 frame is received correctly.
REQ-027 Assert rst at cycle 40 of a frame, release it, then send 0x99 -> only 0x99 reported, RXRDY=1, no errors.

Source files
------------

// File: rtl/uart_rx_engine.sv
// uart_rx_engine: oversampling-free UART receiver, one RX sample per bit
// time; 7/8 data bits, optional odd/even parity, one stop bit.
// Ports: clk, rst (async, active high); EIGHT/PEN/OHEL/k frame config
// latched at start detect; RX serial in; READ_CLR read strobe;
// RX_DATA, RXRDY, PERR, FERR, OVF received character and status.
// UART_RX_SYNC2_EN: adds a 2-flop synchronizer ahead of the RX register.
module uart_rx_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        EIGHT,
  input  logic        PEN,
  input  logic        OHEL,
  input  logic [18:0] k,
  input  logic        RX,
  input  logic        READ_CLR,
  output logic [7:0]  RX_DATA,
  output logic        RXRDY,
  output logic        PERR,
  output logic        FERR,
  output logic        OVF
);

  typedef enum logic [1:0] {
    IDLE,
    START,
    SHIFT,
    STOP
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic        rx_q;
  logic        eight_r;
  logic        pen_r;
  logic        ohel_r;
  logic [18:0] b_r;
  logic [18:0] h_r;
  logic [18:0] timer;
  logic [3:0]  bit_cnt;
  logic [8:0]  bits_r;

  logic [18:0] b_eff;
  logic [3:0]  nbits;
  logic        tick_half;
  logic        tick_bit;
  logic        last_bit;
  logic        start_det;
  logic        half_smp;
  logic        shift_smp;
  logic        frame_done;
  logic [7:0]  data_w;
  logic        par_rx;
  logic        par_calc;
  logic        perr_w;

`ifdef UART_RX_SYNC2_EN
  logic rx_s1;
  logic rx_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_q  <= 1'b1;
    end else begin
      rx_s1 <= RX;
      rx_s2 <= rx_s1;
      rx_q  <= rx_s2;
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_q <= 1'b1;
    else     rx_q <= RX;
  end
`endif

  assign b_eff     = (k < 19'd2) ? 19'd2 : k;
  assign nbits     = 4'd7 + {3'd0, eight_r} + {3'd0, pen_r};
  assign tick_half = (timer == h_r - 19'd1);
  assign tick_bit  = (timer == b_r - 19'd1);
  assign last_bit  = (bit_cnt == nbits - 4'd1);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (!rx_q) state_nx = START;
      START: if (tick_half) state_nx = rx_q ? IDLE : SHIFT;
      SHIFT: if (tick_bit && last_bit) state_nx = STOP;
      STOP:  if (tick_bit) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM strobes
  always_comb begin
    start_det  = 1'b0;
    half_smp   = 1'b0;
    shift_smp  = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      IDLE:  start_det  = ~rx_q;
      START: half_smp   = tick_half;
      SHIFT: shift_smp  = tick_bit;
      STOP:  frame_done = tick_bit;
      default: ;
    endcase
  end

  // Timer, bit counter, shift store, latched frame config
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer   <= '0;
      bit_cnt <= '0;
      bits_r  <= '0;
      eight_r <= 1'b0;
      pen_r   <= 1'b0;
      ohel_r  <= 1'b0;
      b_r     <= 19'd2;
      h_r     <= 19'd1;
    end else begin
      if (start_det) begin
        timer   <= '0;
        bit_cnt <= '0;
        bits_r  <= '0;
        eight_r <= EIGHT;
        pen_r   <= PEN;
        ohel_r  <= OHEL;
        b_r     <= b_eff;
        h_r     <= b_eff >> 1;
      end else if (half_smp || shift_smp || frame_done) begin
        timer <= '0;
      end else if (state != IDLE) begin
        timer <= timer + 19'd1;
      end
      if (shift_smp) begin
        bits_r[bit_cnt] <= rx_q;
        bit_cnt         <= bit_cnt + 4'd1;
      end
    end
  end

  // Data bits land at index 0.., parity right after the last data bit
  assign data_w   = eight_r ? bits_r[7:0] : {1'b0, bits_r[6:0]};
  assign par_rx   = eight_r ? bits_r[8] : bits_r[7];
  assign par_calc = (^data_w) ^ ohel_r;
  assign perr_w   = pen_r & (par_rx != par_calc);

  // A completing frame beats a coincident read strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RX_DATA <= '0;
      RXRDY   <= 1'b0;
      PERR    <= 1'b0;
      FERR    <= 1'b0;
      OVF     <= 1'b0;
    end else if (frame_done) begin
      RX_DATA <= data_w;
      RXRDY   <= 1'b1;
      PERR    <= perr_w;
      FERR    <= ~rx_q;
      OVF     <= RXRDY & ~READ_CLR;
    end else if (READ_CLR) begin
      RXRDY <= 1'b0;
      PERR  <= 1'b0;
      FERR  <= 1'b0;
      OVF   <= 1'b0;
    end
  end

endmodule
